icache_param: RTL and testbench



---
 rtl/icache_param.sv | 165 ++++++++++++++++
 tb/tb_icache_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_param.sv
// N-way set-associative read-only instruction cache with a single line refill port.
// Returns the addressed word plus its in-line successor; hit/miss counters saturate.
module icache_param #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req_i,
    input  logic [ADDR_W-1:0]        cpu_addr_i,
    input  logic                     invalidate_i,
    output logic                     cpu_ready_o,
    output logic                     cpu_inst_valid_o,
    output logic [31:0]              cpu_inst1_o,
    output logic [31:0]              cpu_inst2_o,
    output logic                     cpu_inst2_valid_o,
    output logic                     hit_o,
    output logic                     mem_ren_o,
    output logic [ADDR_W-1:0]        mem_araddr_o,
    input  logic                     mem_rvalid_i,
    input  logic [32*LINE_WORDS-1:0] mem_rdata_i,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o
);

    localparam int WORD_W    = $clog2(LINE_WORDS);
    localparam int OFF_W     = WORD_W + 2;
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
    localparam int PTR_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_BITS = 32 * LINE_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_RESP} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:2]    addr_q;
    logic [TAG_W-1:0]     tag_q;
    logic [IDX_W-1:0]     idx_q;
    logic [WORD_W-1:0]    word_q;
    logic [WORD_W-1:0]    word_nx;

    logic [LINE_BITS-1:0] data_mem [WAYS][SETS];
    logic [TAG_W-1:0]     tag_mem  [WAYS][SETS];
    logic [WAYS-1:0]      valid_q  [SETS];
    logic [PTR_W-1:0]     ptr_q    [SETS];
    logic [LINE_BITS-1:0] line_q;

    logic [31:0]          hit_cnt_q, miss_cnt_q;

    logic                 hit;
    logic [PTR_W-1:0]     hit_way;
    logic                 has_invalid;
    logic [PTR_W-1:0]     victim;
    logic                 accept, fill, resp_valid, last_word;
    logic [LINE_BITS-1:0] sel_line;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign tag_q   = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_q   = addr_q[OFF_W +: IDX_W];
    assign word_q  = addr_q[2 +: WORD_W];
    assign word_nx = word_q + 1'b1;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!hit && valid_q[idx_q][i] && (tag_mem[i][idx_q] == tag_q)) begin
                hit     = 1'b1;
                hit_way = PTR_W'(i);
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        has_invalid = 1'b0;
        victim      = ptr_q[idx_q];
        for (int i = 0; i < WAYS; i++) begin
            if (!has_invalid && !valid_q[idx_q][i]) begin
                has_invalid = 1'b1;
                victim      = PTR_W'(i);
            end
        end
    end

    assign accept = (state_q == S_IDLE) && cpu_req_i && !invalidate_i;
    assign fill   = (state_q == S_MISS) && mem_rvalid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_LOOKUP;
            S_LOOKUP: state_d = hit ? S_IDLE : S_MISS;
            S_MISS:   if (mem_rvalid_i) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept)
                addr_q <= cpu_addr_i[ADDR_W-1:2];
            if ((state_q == S_IDLE) && invalidate_i) begin
                for (int s = 0; s < SETS; s++)
                    valid_q[s] <= '0;
            end
            if (fill) begin
                valid_q[idx_q][victim] <= 1'b1;
                if (!has_invalid)
                    ptr_q[idx_q] <= (ptr_q[idx_q] == PTR_W'(WAYS-1)) ? '0 : ptr_q[idx_q] + 1'b1;
            end
            if (state_q == S_LOOKUP) begin
                if (hit && (hit_cnt_q != '1))
                    hit_cnt_q <= hit_cnt_q + 1'b1;
                if (!hit && (miss_cnt_q != '1))
                    miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: data/tag arrays and the refill buffer are not reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[victim][idx_q] <= mem_rdata_i;
            tag_mem[victim][idx_q]  <= tag_q;
            line_q                  <= mem_rdata_i;
        end
    end

    assign resp_valid = ((state_q == S_LOOKUP) && hit) || (state_q == S_RESP);
    assign sel_line   = (state_q == S_RESP) ? line_q : data_mem[hit_way][idx_q];
    assign last_word  = &word_q;

    assign cpu_ready_o       = (state_q == S_IDLE);
    assign cpu_inst_valid_o  = resp_valid;
    assign hit_o             = resp_valid && (state_q == S_LOOKUP);
    assign cpu_inst1_o       = resp_valid ? sel_line[32*word_q +: 32] : 32'h0;
    // The successor word never wraps into the same line.
    assign cpu_inst2_valid_o = resp_valid && !last_word;
    assign cpu_inst2_o       = (resp_valid && !last_word) ? sel_line[32*word_nx +: 32] : 32'h0;

    assign mem_ren_o    = (state_q == S_MISS);
    assign mem_araddr_o = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_icache_param.sv
// Randomized self-checking bench for icache_param against a behavioural cache model
// (line contents are a pure function of the line address, so any hit must reproduce it).
module tb_icache_param;

    localparam int WAYS       = 2;
    localparam int SETS       = 128;
    localparam int LINE_WORDS = 8;
    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = LINE_WORDS * 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cpu_req_i;
    logic [ADDR_W-1:0]        cpu_addr_i;
    logic                     invalidate_i;
    logic                     cpu_ready_o;
    logic                     cpu_inst_valid_o;
    logic [31:0]              cpu_inst1_o;
    logic [31:0]              cpu_inst2_o;
    logic                     cpu_inst2_valid_o;
    logic                     hit_o;
    logic                     mem_ren_o;
    logic [ADDR_W-1:0]        mem_araddr_o;
    logic                     mem_rvalid_i;
    logic [32*LINE_WORDS-1:0] mem_rdata_i;
    logic [31:0]              hit_cnt_o;
    logic [31:0]              miss_cnt_o;

    icache_param #(
        .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .invalidate_i(invalidate_i),
        .cpu_ready_o(cpu_ready_o), .cpu_inst_valid_o(cpu_inst_valid_o),
        .cpu_inst1_o(cpu_inst1_o), .cpu_inst2_o(cpu_inst2_o),
        .cpu_inst2_valid_o(cpu_inst2_valid_o), .hit_o(hit_o),
        .mem_ren_o(mem_ren_o), .mem_araddr_o(mem_araddr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: which line addresses each set holds, per way.
    bit          m_valid [WAYS][SETS];
    int unsigned m_tag   [WAYS][SETS];
    int          m_ptr   [SETS];
    int unsigned m_hits, m_misses;

    function automatic logic [31:0] mem_word(input logic [31:0] line, input int k);
        return 32'hA000_0000 + ((line - 32'h1000) << 8) + 32'(k);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[w][s] = 1'b0;
                m_tag[w][s]   = 0;
            end
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_invalidate();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                m_valid[w][s] = 1'b0;
    endtask

    task automatic check_resp(input logic [31:0] addr, input bit exp_hit);
        logic [31:0] line;
        int          w;
        line = addr & ~32'(LINE_BYTES-1);
        w    = int'((addr % LINE_BYTES) / 4);
        check("inst_valid", cpu_inst_valid_o, 1);
        check("hit_o", hit_o, exp_hit);
        check("inst1", cpu_inst1_o, mem_word(line, w));
        if (w < LINE_WORDS-1) begin
            check("inst2", cpu_inst2_o, mem_word(line, w+1));
            check("inst2_valid", cpu_inst2_valid_o, 1);
        end else begin
            check("inst2_edge", cpu_inst2_o, 0);
            check("inst2_valid_edge", cpu_inst2_valid_o, 0);
        end
    endtask

    // One request end to end; on a miss the bench acts as memory after lat extra cycles.
    task automatic do_request(input logic [31:0] addr, input int lat);
        logic [31:0] line;
        int          set, victim;
        int unsigned tag;
        bit          hit;
        line = addr & ~32'(LINE_BYTES-1);
        set  = int'((addr / LINE_BYTES) % SETS);
        tag  = addr / (LINE_BYTES * SETS);
        hit  = 1'b0;
        for (int i = 0; i < WAYS; i++)
            if (m_valid[i][set] && m_tag[i][set] == tag) hit = 1'b1;

        @(negedge clk);
        check("ready_idle", cpu_ready_o, 1);
        cpu_req_i  = 1'b1;
        cpu_addr_i = addr;
        @(posedge clk); #1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = $urandom;
        check("ready_busy", cpu_ready_o, 0);
        if (hit) begin
            m_hits++;
            check_resp(addr, 1'b1);
            check("ren_on_hit", mem_ren_o, 0);
        end else begin
            m_misses++;
            check("lookup_no_valid", cpu_inst_valid_o, 0);
            @(posedge clk); #1;
            for (int c = 0; c <= lat; c++) begin
                check("mem_ren", mem_ren_o, 1);
                check("araddr", mem_araddr_o, line);
                check("miss_no_valid", cpu_inst_valid_o, 0);
                invalidate_i = 1'($urandom_range(0, 1));
                if (c == lat) begin
                    mem_rvalid_i = 1'b1;
                    for (int k = 0; k < LINE_WORDS; k++)
                        mem_rdata_i[32*k +: 32] = mem_word(line, k);
                end
                @(posedge clk); #1;
                invalidate_i = 1'b0;
            end
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = {LINE_WORDS{$urandom}};
            check("resp_ren_low", mem_ren_o, 0);
            check_resp(addr, 1'b0);
            victim = -1;
            for (int i = 0; i < WAYS; i++)
                if (victim < 0 && !m_valid[i][set]) victim = i;
            if (victim < 0) begin
                victim     = m_ptr[set];
                m_ptr[set] = (m_ptr[set] + 1) % WAYS;
            end
            m_valid[victim][set] = 1'b1;
            m_tag[victim][set]   = tag;
        end
        @(posedge clk); #1;
        check("hit_cnt", hit_cnt_o, m_hits);
        check("miss_cnt", miss_cnt_o, m_misses);
    endtask

    task automatic do_invalidate(input bit with_req, input logic [31:0] addr);
        @(negedge clk);
        invalidate_i = 1'b1;
        cpu_req_i    = with_req;
        cpu_addr_i   = addr;
        @(posedge clk); #1;
        invalidate_i = 1'b0;
        cpu_req_i    = 1'b0;
        model_invalidate();
        check("inv_not_accepted", cpu_ready_o, 1);
        check("inv_no_valid", cpu_inst_valid_o, 0);
        check("inv_no_ren", mem_ren_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        cpu_req_i    = 1'b0;
        cpu_addr_i   = '0;
        invalidate_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        model_reset();
        #1;
        check("rst_ready", cpu_ready_o, 1);
        check("rst_ren", mem_ren_o, 0);
        check("rst_araddr", mem_araddr_o, 0);
        check("rst_valid", cpu_inst_valid_o, 0);
        check("rst_hit_cnt", hit_cnt_o, 0);
        check("rst_miss_cnt", miss_cnt_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Cold miss, hit after fill, line edge.
        do_request(32'h0000_1004, 5);
        do_request(32'h0000_1008, 0);
        do_request(32'h0000_101C, 0);

        // Replacement in set 0.
        do_request(32'h0000_2004, 2);
        do_request(32'h0000_3004, 1);
        do_request(32'h0000_2004, 0);
        do_request(32'h0000_1004, 3);

        // Invalidate has priority over a same-cycle request.
        do_invalidate(1'b1, 32'h0000_1004);
        do_request(32'h0000_1004, 2);

        // Reset in the middle of a refill.
        do_invalidate(1'b0, 32'h0);
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_1004;
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_ren", mem_ren_o, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("midrst_ren", mem_ren_o, 0);
        check("midrst_ready", cpu_ready_o, 1);
        check("midrst_hit_cnt", hit_cnt_o, 0);
        check("midrst_miss_cnt", miss_cnt_o, 0);
        check("midrst_araddr", mem_araddr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        check("late_rvalid_ready", cpu_ready_o, 1);
        check("late_rvalid_valid", cpu_inst_valid_o, 0);
        do_request(32'h0000_1004, 1);

        // Random traffic over a few conflicting sets.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(1, 6)) << 12) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, LINE_WORDS-1)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                do_invalidate(1'($urandom_range(0, 1)), a);
            else
                do_request(a, int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
